// File: rtl/aes_key_schedule.sv
// rtl/aes_key_schedule.sv - AES-128 key expansion: roundKey iterated once per clock into a round-key bank
// Optional feature macro: KEYSCHED_ZEROIZE_EN (adds zeroize input and bank reset)

module aes_round_key (
  input  logic [127:0] key_in,
  input  logic [3:0]   round,
  output logic [127:0] key_out
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (0 maps to 0), then the FIPS-197 affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  logic [7:0]  rcon;
  logic [31:0] w0, w1, w2, w3, rot, temp, n0, n1, n2, n3;

  always_comb begin
    rcon = 8'h00;
    case (round)
      4'd0: rcon = 8'h01;
      4'd1: rcon = 8'h02;
      4'd2: rcon = 8'h04;
      4'd3: rcon = 8'h08;
      4'd4: rcon = 8'h10;
      4'd5: rcon = 8'h20;
      4'd6: rcon = 8'h40;
      4'd7: rcon = 8'h80;
      4'd8: rcon = 8'h1b;
      4'd9: rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign w0   = key_in[127:96];
  assign w1   = key_in[95:64];
  assign w2   = key_in[63:32];
  assign w3   = key_in[31:0];
  assign rot  = {w3[23:0], w3[31:24]};
  assign temp = {sbox(rot[31:24]) ^ rcon, sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
  assign n0   = w0 ^ temp;
  assign n1   = w1 ^ n0;
  assign n2   = w2 ^ n1;
  assign n3   = w3 ^ n2;
  assign key_out = {n0, n1, n2, n3};

endmodule

module aes_key_schedule #(
  parameter int NR    = 10,
  parameter int KEY_W = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [KEY_W-1:0] key_in,
  output logic             busy,
  output logic             keys_valid,
  input  logic [3:0]       rd_idx,
  output logic [KEY_W-1:0] rd_key
`ifdef KEYSCHED_ZEROIZE_EN
  ,
  input  logic             zeroize
`endif
);

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  localparam logic [3:0] LAST_CNT = 4'(NR - 1);
  localparam logic [3:0] LAST_IDX = 4'(NR);

  state_t           state, state_next;
  logic [3:0]       cnt;
  logic [KEY_W-1:0] bank [0:NR];
  logic [KEY_W-1:0] next_key;
  logic             zero_req;
  logic             load;
  logic             bank_we;
  logic [3:0]       bank_waddr;
  logic [KEY_W-1:0] bank_wdata;

`ifdef KEYSCHED_ZEROIZE_EN
  assign zero_req = zeroize;
`else
  assign zero_req = 1'b0;
`endif

  assign load = start && (state != EXPAND) && !zero_req;

  aes_round_key u_round_key (
    .key_in  (bank[cnt]),
    .round   (cnt),
    .key_out (next_key)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (zero_req) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE, DONE: if (start) state_next = EXPAND;
        EXPAND:     if (cnt == LAST_CNT) state_next = DONE;
        default:    state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    busy       = (state == EXPAND);
    keys_valid = (state == DONE);
  end

  // cnt holds at NR-1 on the final expansion edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                    cnt <= 4'd0;
    else if (zero_req || load)                  cnt <= 4'd0;
    else if (state == EXPAND && cnt != LAST_CNT) cnt <= cnt + 4'd1;
  end

  always_comb begin
    bank_we    = 1'b0;
    bank_waddr = 4'd0;
    bank_wdata = next_key;
    if (load) begin
      bank_we    = 1'b1;
      bank_wdata = key_in;
    end else if (state == EXPAND && !zero_req) begin
      bank_we    = 1'b1;
      bank_waddr = cnt + 4'd1;
    end
  end

`ifdef KEYSCHED_ZEROIZE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst || zero_req) begin
      for (int i = 0; i <= NR; i++) bank[i] <= '0;
    end else if (bank_we) begin
      bank[bank_waddr] <= bank_wdata;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (bank_we) bank[bank_waddr] <= bank_wdata;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    rd_key <= '0;
    else if (zero_req)          rd_key <= '0;
    else if (rd_idx <= LAST_IDX) rd_key <= bank[rd_idx];
    else                        rd_key <= '0;
  end

endmodule

// File: tb/tb_aes_key_schedule.sv
// tb/tb_aes_key_schedule.sv - scoreboard bench for aes_key_schedule against a word-level FIPS-197 model
// Zeroize scenarios are compiled in with KEYSCHED_ZEROIZE_EN

module tb_aes_key_schedule;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [127:0] key_in = '0;
  logic         busy;
  logic         keys_valid;
  logic [3:0]   rd_idx = '0;
  logic [127:0] rd_key;
`ifdef KEYSCHED_ZEROIZE_EN
  logic         zeroize = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [127:0] exp_q[$];
  logic         req_v = 1'b0;
  logic         req_pend = 1'b0;

  logic [7:0]   sbox_tab [256];
  logic [127:0] model [0:10];

  localparam logic [127:0] FIPS_KEY = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [127:0] FIPS_R1  = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
  localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb_3e92e211_23e951cf_6f8f188e;

  always #5 clk = ~clk;

  aes_key_schedule dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .key_in     (key_in),
    .busy       (busy),
    .keys_valid (keys_valid),
    .rd_idx     (rd_idx),
    .rd_key     (rd_key)
`ifdef KEYSCHED_ZEROIZE_EN
    ,
    .zeroize    (zeroize)
`endif
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a read issued before edge N is answered on rd_key after edge N
  always @(posedge clk) req_pend <= req_v;

  always @(negedge clk) begin
    if (req_pend) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rd_key_unexpected: got %h expected no read", rd_key);
      end else begin
        check("rd_key", rd_key, exp_q.pop_front());
      end
    end
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box table: brute-force inverse search followed by the bitwise affine formula
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] b = 8'h00;
      logic [7:0] s;
      logic [7:0] c = 8'h63;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = b[i] ^ b[(i + 4) % 8] ^ b[(i + 5) % 8] ^ b[(i + 6) % 8] ^ b[(i + 7) % 8] ^ c[i];
      sbox_tab[x] = s;
    end
  endtask

  task automatic build_model(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i - 1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_tab[t[31:24]] ^ rc, sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i - 4] ^ t;
    end
    for (int r = 0; r <= 10; r++) model[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic rd(input logic [3:0] idx, input logic [127:0] exp);
    rd_idx = idx;
    req_v  = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    req_v  = 1'b0;
  endtask

  task automatic drain();
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic read_all();
    for (int i = 0; i < 16; i++) rd(4'(i), (i <= 10) ? model[i] : 128'h0);
    drain();
  endtask

  // Called 1 time unit after an edge; leaves the bench 1 unit after the edge where keys_valid rose
  task automatic run_expand(input logic [127:0] k, input int restart_at, input logic [127:0] k2);
    start  = 1'b1;
    key_in = k;
    @(posedge clk); #1;
    start  = 1'b0;
    key_in = rand128();
    for (int c = 1; c <= 10; c++) begin
      check($sformatf("busy_c%0d", c), 128'(busy), 128'd1);
      check($sformatf("kv_low_c%0d", c), 128'(keys_valid), 128'd0);
      if (c == restart_at) begin
        start  = 1'b1;
        key_in = k2;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    check("busy_done", 128'(busy), 128'd0);
    check("kv_done", 128'(keys_valid), 128'd1);
    build_model(k);
  endtask

  initial begin
    build_sbox();

    #2 rst = 1'b1;
    #1;
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_kv", 128'(keys_valid), 128'd0);
    check("rst_rd_key", rd_key, 128'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // FIPS-197 vector, spec constants for slots 0, 1, 10
    run_expand(FIPS_KEY, -1, '0);
    rd(4'd0, FIPS_KEY);
    rd(4'd1, FIPS_R1);
    rd(4'd10, FIPS_R10);
    drain();
    read_all();

    // start during EXPAND is ignored
    begin
      logic [127:0] ka = rand128();
      run_expand(ka, 4, rand128());
      read_all();
    end

    // async reset mid-expansion, then a clean run
    start  = 1'b1;
    key_in = rand128();
    @(posedge clk); #1;
    start  = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", 128'(busy), 128'd0);
    check("midrst_kv", 128'(keys_valid), 128'd0);
    @(posedge clk); #1;
    check("midrst_hold_kv", 128'(keys_valid), 128'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    run_expand(rand128(), -1, '0);
    read_all();

    // back-to-back restart from DONE with the all-zero key
    run_expand(128'h0, -1, '0);
    rd(4'd10, ZERO_R10);
    drain();
    read_all();

    // random keys, random reads
    for (int n = 0; n < 4; n++) begin
      run_expand(rand128(), -1, '0);
      for (int j = 0; j < 8; j++) begin
        int idx = $urandom_range(0, 15);
        rd(4'(idx), (idx <= 10) ? model[idx] : 128'h0);
      end
      drain();
    end

`ifdef KEYSCHED_ZEROIZE_EN
    zeroize = 1'b1;
    @(posedge clk); #1;
    zeroize = 1'b0;
    check("zero_kv", 128'(keys_valid), 128'd0);
    check("zero_busy", 128'(busy), 128'd0);
    check("zero_rd_key", rd_key, 128'd0);
    for (int i = 0; i <= 10; i++) rd(4'(i), 128'h0);
    drain();

    run_expand(rand128(), -1, '0);
    zeroize = 1'b1;
    start   = 1'b1;
    key_in  = rand128();
    @(posedge clk); #1;
    zeroize = 1'b0;
    start   = 1'b0;
    check("zero_start_busy", 128'(busy), 128'd0);
    check("zero_start_kv", 128'(keys_valid), 128'd0);
    @(posedge clk); #1;
    check("zero_start_idle", 128'(busy), 128'd0);
`endif

    drain();
    check("scoreboard_empty", 128'(exp_q.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
